// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq_pkg
//  Brief    : Shared types and constants for the iterative shift unit.
//  Revision : 1.0
// ============================================================================
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    localparam int NUM_STAGES = 5;
    localparam int STEP_W     = 3;

endpackage
`default_nettype wire

// File: rtl/shift_seq_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_stage
//  Brief    : One conditional power-of-two shift stage, distance 2^step.
//  Revision : 1.0
// ============================================================================
module shift_stage
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]  acc,
    input  logic [STEP_W-1:0] step,
    input  logic              en,
    input  logic [1:0]        op,
    output logic [WIDTH-1:0]  acc_out
);

    logic [SHAMT_W-1:0] w_dist;

    always_comb begin
        w_dist  = SHAMT_W'(1) << step;
        acc_out = acc;
        if (en) begin
            case (op)
                OP_SLL:  acc_out = acc << w_dist;
                OP_SRL:  acc_out = acc >> w_dist;
                // OP_SRA and the reserved encoding both sign-fill
                default: acc_out = WIDTH'($signed(acc) >>> w_dist);
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq
//  Brief    : Multi-cycle SLL/SRL/SRA unit, one power-of-two stage per cycle
//             (16, 8, 4, 2, 1). Define SHIFT_SEQ_EARLY_EXIT_EN to finish as
//             soon as no lower amount bits remain.
//  Revision : 1.0
// ============================================================================
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_SHIFT,
    input  logic [1:0]         ctrl_shiftop,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    localparam logic [STEP_W-1:0] C_STEP_TOP = STEP_W'(NUM_STAGES - 1);

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [WIDTH-1:0]    r_acc;
    logic [SHAMT_W-1:0]  r_amt;
    logic [1:0]          r_op;
    logic [WIDTH-1:0]    r_result;

    state_t              w_state_nxt;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [WIDTH-1:0]    w_acc_nxt;
    logic [SHAMT_W-1:0]  w_amt_nxt;
    logic [1:0]          w_op_nxt;
    logic [WIDTH-1:0]    w_result_nxt;

    logic [SHAMT_W-1:0]  w_bit_sel;
    logic                w_en;
    logic                w_last;
    logic [WIDTH-1:0]    w_stage_out;

    assign w_bit_sel = SHAMT_W'(1) << r_step;
    assign w_en      = |(r_amt & w_bit_sel);

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    // Finish once every amount bit below the current stage is clear
    assign w_last = ((r_amt & (w_bit_sel - SHAMT_W'(1))) == '0);
`else
    assign w_last = (r_step == '0);
`endif

    shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .acc     (r_acc),
        .step    (r_step),
        .en      (w_en),
        .op      (r_op),
        .acc_out (w_stage_out)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_step_nxt   = r_step;
        w_acc_nxt    = r_acc;
        w_amt_nxt    = r_amt;
        w_op_nxt     = r_op;
        w_result_nxt = r_result;
        case (r_state)
            IDLE, DONE: begin
                if (ctrl_SHIFT) begin
                    w_state_nxt = SHIFT;
                    w_step_nxt  = C_STEP_TOP;
                    w_acc_nxt   = data_operandA;
                    w_amt_nxt   = ctrl_shiftamt;
                    w_op_nxt    = ctrl_shiftop;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                w_acc_nxt = w_stage_out;
                if (r_step != '0) begin
                    w_step_nxt = r_step - STEP_W'(1);
                end
                if (w_last) begin
                    w_state_nxt  = DONE;
                    w_result_nxt = w_stage_out;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_step   <= C_STEP_TOP;
            r_acc    <= '0;
            r_amt    <= '0;
            r_op     <= '0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_acc    <= w_acc_nxt;
            r_amt    <= w_amt_nxt;
            r_op     <= w_op_nxt;
            r_result <= w_result_nxt;
        end
    end

    assign data_result    = r_result;
    assign data_resultRDY = (r_state == DONE);
    assign busy           = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_shift_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_seq
//  Brief    : Self-checking bench for shift_seq (vector table + random ops).
//  Revision : 1.0
// ============================================================================
module tb_shift_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_SHIFT = 1'b0;
    logic [1:0]  ctrl_shiftop = 2'b00;
    logic [31:0] data_operandA = '0;
    logic [4:0]  ctrl_shiftamt = '0;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    shift_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_SHIFT     (ctrl_SHIFT),
        .ctrl_shiftop   (ctrl_shiftop),
        .data_operandA  (data_operandA),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the whole shift in one arithmetic expression
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
        case (op)
            2'b00:   return a << amt;
            2'b01:   return a >> amt;
            default: return $signed(a) >>> amt;
        endcase
    endfunction

    // SHIFT-state edges between the accepting edge and the DONE state
    function automatic int exp_lat(input logic [4:0] amt);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (amt == 0) return 1;
        for (int k = 0; k < 5; k++) if (amt[k]) return 5 - k;
        return 5;
`else
        return 5;
`endif
    endfunction

    // Runs one operation; pulse_at>0 drives a second start at that edge index.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] amt, input logic [31:0] exp, input int pulse_at);
        int lat, busy_cnt, rdy_cnt, rdy_edge;
        logic [31:0] res;
        lat = exp_lat(amt);
        busy_cnt = 0; rdy_cnt = 0; rdy_edge = -1; res = 'x;
        @(negedge clock);
        ctrl_shiftop = op; data_operandA = a; ctrl_shiftamt = amt; ctrl_SHIFT = 1'b1;
        @(posedge clock); #1;
        ctrl_SHIFT = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            if (e > 0) begin
                @(posedge clock); #1;
            end
            if (pulse_at > 0 && e == pulse_at - 1) begin
                ctrl_SHIFT = 1'b1; data_operandA = 32'hDEADBEEF;
                ctrl_shiftop = 2'b00; ctrl_shiftamt = 5'd3;
            end else begin
                ctrl_SHIFT = 1'b0;
            end
            if (busy) busy_cnt++;
            if (data_resultRDY) begin
                rdy_cnt++;
                rdy_edge = e;
                res = data_result;
            end
        end
        chk({name, " result"}, res, exp);
        chk({name, " rdy_edge"}, rdy_edge, lat);
        chk({name, " rdy_cnt"}, rdy_cnt, 1);
        chk({name, " busy_cnt"}, busy_cnt, lat);
        chk({name, " held"}, data_result, exp);
    endtask

    vec_t vecs[9];

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [4:0]  ramt;
        int          lat;
        bit          seen;

        vecs[0] = '{2'b10, 32'h80000000, 5'd4,  32'hF8000000};
        vecs[1] = '{2'b00, 32'h00000001, 5'd31, 32'h80000000};
        vecs[2] = '{2'b01, 32'hF0000000, 5'd28, 32'h0000000F};
        vecs[3] = '{2'b10, 32'hF0000000, 5'd28, 32'hFFFFFFFF};
        vecs[4] = '{2'b11, 32'h80000000, 5'd31, 32'hFFFFFFFF};
        vecs[5] = '{2'b00, 32'h12345678, 5'd0,  32'h12345678};
        vecs[6] = '{2'b01, 32'h80000000, 5'd31, 32'h00000001};
        vecs[7] = '{2'b00, 32'hFFFFFFFF, 5'd16, 32'hFFFF0000};
        vecs[8] = '{2'b10, 32'h7FFFFFFF, 5'd30, 32'h00000001};

        #12;
        chk("reset result", data_result, 32'h0);
        chk("reset rdy", {31'b0, data_resultRDY}, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].amt, vecs[i].exp, 0);

        // Start pulse while shifting must be ignored
        run_op("ignored_start", 2'b01, 32'h00000100, 5'd8, 32'h00000001, 2);

        // Asynchronous reset while step 2 is pending
        @(negedge clock);
        ctrl_shiftop = 2'b00; data_operandA = 32'hA5A5A5A5; ctrl_shiftamt = 5'd7; ctrl_SHIFT = 1'b1;
        @(posedge clock); #1; ctrl_SHIFT = 1'b0;
        @(posedge clock);
        @(posedge clock); #3;
        reset = 1'b1; #1;
        chk("abort result", data_result, 32'h0);
        chk("abort rdy", {31'b0, data_resultRDY}, 32'h0);
        chk("abort busy", {31'b0, busy}, 32'h0);
        @(negedge clock); reset = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clock); #1;
            if (data_resultRDY) seen = 1'b1;
        end
        chk("abort no_rdy", {31'b0, seen}, 32'h0);
        run_op("post_abort", 2'b00, 32'h3, 5'd1, 32'h6, 0);

        // Start asserted in the RDY cycle is accepted
        @(negedge clock);
        ctrl_shiftop = 2'b00; data_operandA = 32'h12345678; ctrl_shiftamt = 5'd0; ctrl_SHIFT = 1'b1;
        @(posedge clock); #1; ctrl_SHIFT = 1'b0;
        lat = exp_lat(5'd0);
        for (int e = 1; e <= lat; e++) begin
            @(posedge clock); #1;
        end
        chk("b2b first_rdy", {31'b0, data_resultRDY}, 32'h1);
        chk("b2b first_res", data_result, 32'h12345678);
        ctrl_shiftop = 2'b01; data_operandA = 32'h000000F0; ctrl_shiftamt = 5'd4; ctrl_SHIFT = 1'b1;
        @(posedge clock); #1; ctrl_SHIFT = 1'b0;
        chk("b2b accepted", {31'b0, busy}, 32'h1);
        chk("b2b held", data_result, 32'h12345678);
        lat = exp_lat(5'd4);
        seen = 1'b0;
        for (int e = 1; e <= lat; e++) begin
            @(posedge clock); #1;
            if (e < lat && data_resultRDY) seen = 1'b1;
        end
        chk("b2b early_rdy", {31'b0, seen}, 32'h0);
        chk("b2b second_rdy", {31'b0, data_resultRDY}, 32'h1);
        chk("b2b second_res", data_result, 32'h0000000F);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            ra   = $urandom;
            ramt = 5'($urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), rop, ra, ramt, model(rop, ra, ramt), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
